// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, sizes and decode helper for the register file
package regfile_pkg;
    localparam int REG_WIDTH = 64;
    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;
    localparam int XZR_IDX   = 31;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [REG_WIDTH-1:0] reg_data_t;

    // One-hot 3:8 leaf decoder; all-zero when disabled so unknown indices stay harmless.
    function automatic logic [7:0] dec3_8(input logic en, input logic [2:0] idx);
        dec3_8 = 8'b0;
        if (en) begin
            dec3_8[idx] = 1'b1;
        end
    endfunction
endpackage

// File: rtl/decoder5_32.sv
// rtl/decoder5_32.sv - 5-to-32 one-hot decoder with enable, 2:4 front stage feeding four 3:8 leaves
module decoder5_32
    import regfile_pkg::*;
(
    input  logic        i_en,
    input  reg_idx_t    i_idx,
    output logic [31:0] o_onehot
);
    logic [3:0] w_hi;

    assign w_hi = i_en ? (4'b0001 << i_idx[4:3]) : 4'b0000;

    for (genvar g = 0; g < 4; g++) begin : g_leaf
        assign o_onehot[8*g +: 8] = dec3_8(w_hi[g], i_idx[2:0]);
    end
endmodule

// File: rtl/mux64x32_1.sv
// rtl/mux64x32_1.sv - 64-bit 32:1 combinational read mux
module mux64x32_1
    import regfile_pkg::*;
(
    input  reg_data_t i_data [NUM_REGS],
    input  reg_idx_t  i_sel,
    output reg_data_t o_data
);
    assign o_data = i_data[i_sel];
endmodule

// File: rtl/regfile_cell.sv
// rtl/regfile_cell.sv - enabled D flip-flop bank with synchronous clear
module regfile_cell #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/regfile_32x64.sv
// rtl/regfile_32x64.sv - 32x64 register file, one write port, two combinational read ports, XZR at index 31
module regfile_32x64
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);
    logic [31:0] w_we;
    reg_data_t   w_regs [NUM_REGS];
    reg_data_t   w_mux1;
    reg_data_t   w_mux2;
    logic        w_wr_live;
    logic        w_byp1;
    logic        w_byp2;
    logic        w_unused_we;

    decoder5_32 u_dec (
        .i_en     (RegWrite),
        .i_idx    (WriteRegister),
        .o_onehot (w_we)
    );

    // The zero register has no cell, so its decoder output goes nowhere.
    assign w_unused_we = w_we[ZERO_REG];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (g == ZERO_REG) begin : g_xzr
            assign w_regs[g] = '0;
        end else begin : g_cell
            regfile_cell #(.WIDTH(REG_WIDTH)) u_cell (
                .clk   (clk),
                .reset (reset),
                .i_en  (w_we[g]),
                .i_d   (WriteData),
                .o_q   (w_regs[g])
            );
        end
    end

    mux64x32_1 u_mux1 (.i_data(w_regs), .i_sel(ReadRegister1), .o_data(w_mux1));
    mux64x32_1 u_mux2 (.i_data(w_regs), .i_sel(ReadRegister2), .o_data(w_mux2));

    // Forward the in-flight write so a consumer in the same cycle sees write-before-read.
    assign w_wr_live = (BYPASS != 0) && RegWrite && !reset
                       && (WriteRegister != reg_idx_t'(ZERO_REG));
    assign w_byp1    = w_wr_live && (WriteRegister == ReadRegister1);
    assign w_byp2    = w_wr_live && (WriteRegister == ReadRegister2);

    assign ReadData1 = w_byp1 ? WriteData : w_mux1;
    assign ReadData2 = w_byp2 ? WriteData : w_mux2;
endmodule

// File: tb/tb_regfile_32x64.sv
// tb/tb_regfile_32x64.sv - directed self-checking bench for regfile_32x64 with and without bypass
module tb_regfile_32x64;
    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] rd1, rd2, rd1_nb, rd2_nb;
    int          checks = 0;
    int          errors = 0;

    localparam logic [63:0] STEP = 64'h0101_0101_0101_0101;

    always #5 clk = ~clk;

    regfile_32x64 #(.WIDTH(64), .ZERO_REG(31), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rd1), .ReadData2(rd2)
    );

    regfile_32x64 #(.WIDTH(64), .ZERO_REG(31), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rd1_nb), .ReadData2(rd2_nb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = '1;
        ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
        tick();
        reset = 1'b0; RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i); ReadRegister2 = 5'(31 - i);
            #1;
            checks++;
            if ({rd1, rd2, rd1_nb, rd2_nb} !== 256'h0) begin
                errors++;
                $display("FAIL reset_clear idx=%0d got %h %h %h %h want 0", i, rd1, rd2, rd1_nb, rd2_nb);
            end
        end
    endtask

    task automatic test_basic();
        RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 64'hDEAD_BEEF_0123_4567;
        tick();
        WriteRegister = 5'd30; WriteData = 64'h8000_0000_0000_0001;
        tick();
        RegWrite = 1'b0; ReadRegister1 = 5'd5; ReadRegister2 = 5'd30;
        #1;
        checks++;
        if ({rd1, rd2, rd1_nb, rd2_nb} !== {2{64'hDEAD_BEEF_0123_4567, 64'h8000_0000_0000_0001}}) begin
            errors++;
            $display("FAIL basic_rw got %h %h %h %h want deadbeef01234567 8000000000000001", rd1, rd2, rd1_nb, rd2_nb);
        end
        ReadRegister1 = 5'd4; ReadRegister2 = 5'd6;
        #1;
        checks++;
        if ({rd1, rd2, rd1_nb, rd2_nb} !== 256'h0) begin
            errors++;
            $display("FAIL basic_neighbors got %h %h %h %h want 0", rd1, rd2, rd1_nb, rd2_nb);
        end
    endtask

    task automatic test_zero_reg();
        RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = 64'h1234;
        ReadRegister1 = 5'd31; ReadRegister2 = 5'd31;
        #1;
        checks++;
        if ({rd1, rd2, rd1_nb, rd2_nb} !== 256'h0) begin
            errors++;
            $display("FAIL xzr_no_bypass got %h %h %h %h want 0", rd1, rd2, rd1_nb, rd2_nb);
        end
        tick();
        RegWrite = 1'b0;
        #1;
        checks++;
        if ({rd1, rd2, rd1_nb, rd2_nb} !== 256'h0) begin
            errors++;
            $display("FAIL xzr_after_write got %h %h %h %h want 0", rd1, rd2, rd1_nb, rd2_nb);
        end
        ReadRegister1 = 5'd5; ReadRegister2 = 5'd30;
        #1;
        checks++;
        if ({rd1, rd2, rd1_nb, rd2_nb} !== {2{64'hDEAD_BEEF_0123_4567, 64'h8000_0000_0000_0001}}) begin
            errors++;
            $display("FAIL xzr_others_kept got %h %h %h %h", rd1, rd2, rd1_nb, rd2_nb);
        end
    endtask

    task automatic test_bypass();
        RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'hAAAA;
        tick();
        WriteData = 64'h5555; ReadRegister1 = 5'd7; ReadRegister2 = 5'd7;
        #1;
        checks++;
        if ({rd1, rd2} !== {2{64'h5555}}) begin
            errors++;
            $display("FAIL bypass_on got %h %h want 5555", rd1, rd2);
        end
        checks++;
        if ({rd1_nb, rd2_nb} !== {2{64'hAAAA}}) begin
            errors++;
            $display("FAIL bypass_off got %h %h want aaaa", rd1_nb, rd2_nb);
        end
        tick();
        RegWrite = 1'b0;
        #1;
        checks++;
        if ({rd1, rd2, rd1_nb, rd2_nb} !== {4{64'h5555}}) begin
            errors++;
            $display("FAIL bypass_after_edge got %h %h %h %h want 5555", rd1, rd2, rd1_nb, rd2_nb);
        end
    endtask

    task automatic test_regwrite_low();
        RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 64'h1111;
        tick();
        RegWrite = 1'b0; WriteData = 64'hFACE; ReadRegister1 = 5'd9; ReadRegister2 = 5'd5;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({rd1, rd1_nb} !== {2{64'h1111}}) begin
                errors++;
                $display("FAIL regwrite_low cyc=%0d got %h %h want 1111", c, rd1, rd1_nb);
            end
        end
        WriteRegister = 'x;
        tick();
        tick();
        WriteRegister = 5'd0;
        #1;
        checks++;
        if ({rd1, rd2, rd1_nb, rd2_nb} !== {64'h1111, 64'hDEAD_BEEF_0123_4567, 64'h1111, 64'hDEAD_BEEF_0123_4567}) begin
            errors++;
            $display("FAIL x_index_safe got %h %h %h %h", rd1, rd2, rd1_nb, rd2_nb);
        end
    endtask

    task automatic test_sweep();
        logic [63:0] e1, e2;
        RegWrite = 1'b1;
        for (int i = 0; i < 31; i++) begin
            WriteRegister = 5'(i); WriteData = 64'(i) * STEP;
            tick();
        end
        RegWrite = 1'b0;
        for (int i = 0; i < 31; i++) begin
            ReadRegister1 = 5'(i); ReadRegister2 = 5'(30 - i);
            e1 = 64'(i) * STEP; e2 = 64'(30 - i) * STEP;
            #1;
            checks++;
            if ({rd1, rd2, rd1_nb, rd2_nb} !== {e1, e2, e1, e2}) begin
                errors++;
                $display("FAIL sweep i=%0d got %h %h %h %h want %h %h", i, rd1, rd2, rd1_nb, rd2_nb, e1, e2);
            end
        end
        ReadRegister1 = 5'd31; ReadRegister2 = 5'd31;
        #1;
        checks++;
        if ({rd1, rd2, rd1_nb, rd2_nb} !== 256'h0) begin
            errors++;
            $display("FAIL sweep_xzr got %h %h %h %h want 0", rd1, rd2, rd1_nb, rd2_nb);
        end
    endtask

    task automatic test_reset_priority();
        reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 64'hFACE;
        ReadRegister1 = 5'd9; ReadRegister2 = 5'd30;
        #1;
        checks++;
        if ({rd1, rd1_nb} !== {2{64'd9 * STEP}}) begin
            errors++;
            $display("FAIL reset_no_bypass got %h %h want %h", rd1, rd1_nb, 64'd9 * STEP);
        end
        tick();
        reset = 1'b0; RegWrite = 1'b0;
        #1;
        checks++;
        if ({rd1, rd2, rd1_nb, rd2_nb} !== 256'h0) begin
            errors++;
            $display("FAIL reset_priority got %h %h %h %h want 0", rd1, rd2, rd1_nb, rd2_nb);
        end
    endtask

    initial begin
        reset = 1'b0; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        #1;
        test_reset();
        test_basic();
        test_zero_reg();
        test_bypass();
        test_regwrite_low();
        test_sweep();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_32x64.md
Name: regfile_32x64

Overview:
- 32-entry × 64-bit architectural register file for the 64-bit ARM datapath.
- Provides one synchronous write port and two combinational read ports.
- Each read port is built from one mux64x32_1, the existing 64-bit 32:1 read mux.
- Sits between the write-back stage, which drives the write port, and the decode/ALU operand path, which consumes ReadData1/ReadData2.
- Register X31 is hardwired to zero (XZR).

Parameters:
- WIDTH, 64: data width of each register. Fixed by the ISA; only 64 is supported.
- ZERO_REG, 31: index of the hardwired-zero register.
- BYPASS, 1: when 1, a same-cycle write is forwarded to a matching read port. When 0, a read returns the old value until the next clock edge.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on rising clk.
- RegWrite  input  1  write enable.
- WriteRegister  input  5  destination register index.
- WriteData  input  64  data to write.
- ReadRegister1  input  5  read port 1 index.
- ReadRegister2  input  5  read port 2 index.
- ReadData1  output  64  read port 1 data (combinational).
- ReadData2  output  64  read port 2 data (combinational).

Behaviour:
- Storage: 31 physical 64-bit registers, X0 to X30, built from D flip-flops. X31 has no storage; its mux input is the constant 64'h0.
- Reset:
  - On a rising clk with reset=1, X0 to X30 all become 0.
  - Reset has priority over RegWrite in the same cycle. The write is dropped.
  - Effect is visible on the reads immediately after that edge.
  - ReadData outputs have no reset value of their own. After reset they read 0 for every index.
- Write:
  - On a rising clk with reset=0 and RegWrite=1, register[WriteRegister] <= WriteData.
  - WriteRegister==31 performs no write.
  - RegWrite=0 leaves all registers unchanged.
  - Exactly one register is enabled, via the one-hot output of a 5:32 decoder gated by RegWrite. Decoder bit 31 is unused.
- Read:
  - Purely combinational from ReadRegisterN through the 32:1 mux. No pipeline register.
  - Valid within the same cycle.
  - Index 31 always returns 0.
  - Both ports may read the same index simultaneously; both return the same value.
- Bypass (BYPASS=1):
  - If RegWrite=1, reset=0, WriteRegister==ReadRegisterN, and WriteRegister!=31, then ReadDataN = WriteData in the same cycle (write-before-read semantics).
  - Applies independently to each port.
  - Never bypasses for index 31.
  - Never bypasses while reset=1.
- BYPASS=0: a read in the write cycle returns the pre-edge value; the new value appears after the edge.
- X and Z inputs on the index ports while RegWrite=0 must not corrupt storage.
- Latency:
  - Write to registered state: 1 clk edge.
  - Read: 0 cycles, combinational.
  - Write to read with bypass: 0 cycles.

Decomposition:
- Shared package regfile_pkg holds:
  - REG_WIDTH=64, NUM_REGS=32, REG_IDX_W=5, XZR_IDX=31.
  - typedef reg_idx_t (logic [4:0]).
  - typedef reg_data_t (logic [63:0]).
- One natural sub-module: decoder5_32, a 5-to-32 one-hot decoder with enable, built hierarchically from smaller decoders.
- The register cell is a 64-bit enabled D flip-flop bank with a synchronous clear, instantiated 31 times by a generate loop.
- The two read paths each instantiate mux64x32_1.

Test Plan:
- Reset: assert reset 1 cycle with RegWrite=1, WriteRegister=3, WriteData=64'hFFFF_FFFF_FFFF_FFFF -> every index 0..31 on both ports reads 64'h0 afterwards (write dropped).
- Basic write/read: write X5=64'hDEAD_BEEF_0123_4567, then X30=64'h8000_0000_0000_0001 -> next cycle ReadRegister1=5 gives 64'hDEAD_BEEF_0123_4567, ReadRegister2=30 gives 64'h8000_0000_0000_0001; X4 and X6 remain 0.
- Zero register: RegWrite=1, WriteRegister=31, WriteData=64'h1234 -> both ports at index 31 read 0, and no other register changes.
- Bypass: registered X7=64'hAAAA; in one cycle RegWrite=1, WriteRegister=7, WriteData=64'h5555, ReadRegister1=ReadRegister2=7 -> both read 64'h5555 before the edge with BYPASS=1, 64'hAAAA with BYPASS=0; 64'h5555 after the edge in both cases.
- RegWrite low: WriteRegister=9, WriteData=64'hFACE, RegWrite=0 for 3 cycles -> X9 stays at its prior value.
- Sweep: write X_i = i*64'h0101_0101_0101_0101 for i=0..30, then read all pairs (i, 30-i) -> exact values, and index 31 reads 0.
